// File: rtl/hbridge_startup_seq.sv
// Full-bridge start-up sequencer: bootstrap charge, tank pre-charge, then handover to
// the hybrid controller, with over-voltage / shoot-through shutdown and bounded retry.
module hbridge_startup_seq #(
   parameter int unsigned BOOT_CYCLES      = 1000,
   parameter int unsigned PRECHARGE_CYCLES = 400,
   parameter int unsigned OV_LIMIT         = 50,
   parameter int unsigned FAULT_HOLD       = 100000,
   parameter int unsigned MAX_RETRY        = 3,
   parameter int unsigned CNT_W            = 20
) (
   input  logic       i_CLK,
   input  logic       i_RST,
   input  logic       i_enable,
   input  logic [3:0] i_Q_ctrl,
   input  logic [7:0] i_vbat,
   output logic [3:0] o_Q,
   output logic       o_ctrl_rst_n,
   output logic [2:0] o_state,
   output logic       o_fault,
   output logic       o_shoot,
   output logic [1:0] o_retry_cnt
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_BOOT      = 3'd1,
      S_PRECHARGE = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4,
      S_LOCKOUT   = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BOOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRECHARGE_CYCLES - 1);
   localparam logic [CNT_W-1:0] FAULT_LAST = CNT_W'(FAULT_HOLD - 1);
   localparam logic [3:0]       Q_BOOT     = 4'b1100;
   localparam logic [3:0]       Q_PRE      = 4'b1001;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             ov;
   logic             shoot;

   assign ov      = i_vbat > 8'(OV_LIMIT);
   assign shoot   = (i_Q_ctrl[0] & i_Q_ctrl[2]) | (i_Q_ctrl[1] & i_Q_ctrl[3]);
   assign o_state = state;

   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         state        <= S_IDLE;
         cnt          <= '0;
         o_Q          <= '0;
         o_ctrl_rst_n <= 1'b0;
         o_fault      <= 1'b0;
         o_shoot      <= 1'b0;
         o_retry_cnt  <= '0;
      end else if (!i_enable) begin
         // sticky flags and retry count survive until the next enable rise
         state        <= S_IDLE;
         cnt          <= '0;
         o_Q          <= '0;
         o_ctrl_rst_n <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state       <= S_BOOT;
               cnt         <= '0;
               o_Q         <= Q_BOOT;
               o_fault     <= 1'b0;
               o_shoot     <= 1'b0;
               o_retry_cnt <= '0;
            end
            S_BOOT: begin
               if (ov) begin
                  state   <= S_FAULT;
                  cnt     <= '0;
                  o_Q     <= '0;
                  o_fault <= 1'b1;
               end else if (cnt == BOOT_LAST) begin
                  state <= S_PRECHARGE;
                  cnt   <= '0;
                  o_Q   <= Q_PRE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_PRECHARGE: begin
               if (ov) begin
                  state   <= S_FAULT;
                  cnt     <= '0;
                  o_Q     <= '0;
                  o_fault <= 1'b1;
               end else if (cnt == PRE_LAST) begin
                  // controller is released on this edge; gates stay off until its first command
                  state        <= S_RUN;
                  cnt          <= '0;
                  o_Q          <= '0;
                  o_ctrl_rst_n <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_RUN: begin
               if (shoot) begin
                  state        <= S_FAULT;
                  cnt          <= '0;
                  o_Q          <= '0;
                  o_ctrl_rst_n <= 1'b0;
                  o_fault      <= 1'b1;
                  o_shoot      <= 1'b1;
               end else if (ov) begin
                  state        <= S_FAULT;
                  cnt          <= '0;
                  o_Q          <= '0;
                  o_ctrl_rst_n <= 1'b0;
                  o_fault      <= 1'b1;
               end else begin
                  o_Q <= i_Q_ctrl;
               end
            end
            S_FAULT: begin
               if (cnt == FAULT_LAST) begin
                  cnt <= '0;
                  if (o_retry_cnt < 2'(MAX_RETRY)) begin
                     state       <= S_BOOT;
                     o_Q         <= Q_BOOT;
                     o_retry_cnt <= o_retry_cnt + 2'd1;
                  end else begin
                     state <= S_LOCKOUT;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_LOCKOUT: begin
               o_Q <= '0;
            end
            default: begin
               state        <= S_IDLE;
               cnt          <= '0;
               o_Q          <= '0;
               o_ctrl_rst_n <= 1'b0;
            end
         endcase
      end
   end

endmodule
